// File: rtl/xext_bridge.sv
`default_nettype none
// ============================================================================
// Module   : xext_bridge
// Purpose  : Bridges a single-cycle CPU access to the external address window
//            onto a req/ack external bus. The CPU is stalled until the slave
//            acknowledges or a timeout expires. Read data is latched for the
//            decoder's read mux, and a timeout raises a one-cycle bus error.
// Ports    : clk            - system clock, rising edge
//            rst            - asynchronous reset, active-low
//            ext_sel        - access strobe from the address decoder
//            we/addr/data_in- CPU access attributes, valid with ext_sel
//            ext_data_to_rd - latched read data for the decoder mux
//            ext_stall      - combinational CPU pipeline hold
//            ext_err        - one-cycle pulse on timeout abort
//            bus_req/we/addr/wdata - external bus request side
//            bus_rdata/bus_ack     - external bus response side
// Revision : 1.0 - initial release
// ============================================================================
module xext_bridge #(
  parameter int DATA_W     = 32,
  parameter int EXT_ADDR_W = 12,
  parameter int TIMEOUT    = 255,
  parameter int TO_W       = 8,
  parameter int ADDR_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ext_sel,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     data_in,
  output logic [DATA_W-1:0]     ext_data_to_rd,
  output logic                  ext_stall,
  output logic                  ext_err,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [EXT_ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic [DATA_W-1:0]     bus_rdata,
  input  logic                  bus_ack
);

  localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_req;
  logic                  r_we;
  logic                  r_err;
  logic [EXT_ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_rdata;
  logic [TO_W-1:0]       r_cnt;
  logic                  w_timeout;

  // Only the low address bits reach the external bus.
  logic w_unused_addr;
  assign w_unused_addr = ^addr[ADDR_W-1:EXT_ADDR_W];

  // Abort only when no ack arrives on the last allowed REQ cycle; an ack on
  // that same cycle still completes the transfer normally.
  assign w_timeout = (r_cnt == c_TO_LAST) && !bus_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (ext_sel) w_next = S_REQ;
      S_REQ:   if (bus_ack || w_timeout) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_err <= 1'b0;
          // bus_ack is deliberately ignored here.
          if (ext_sel) begin
            r_addr  <= addr[EXT_ADDR_W-1:0];
            r_we    <= we;
            r_wdata <= data_in;
            r_req   <= 1'b1;
            r_cnt   <= '0;
          end
        end
        S_REQ: begin
          if (bus_ack) begin
            r_req <= 1'b0;
            if (!r_we) r_rdata <= bus_rdata;
          end else if (w_timeout) begin
            r_req   <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_err <= 1'b0;
        end
        default: begin
          r_req <= 1'b0;
          r_err <= 1'b0;
        end
      endcase
    end
  end

  // DONE is the single cycle in which the CPU is released.
  assign ext_stall      = ext_sel && (r_state != S_DONE);
  assign ext_err        = r_err;
  assign bus_req        = r_req;
  assign bus_we         = r_we;
  assign bus_addr       = r_addr;
  assign bus_wdata      = r_wdata;
  assign ext_data_to_rd = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_xext_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_xext_bridge
// Purpose  : Self-checking bench for xext_bridge. Accesses are driven one at a
//            time; each scenario compares observed stall length, request
//            length, error pulses, bus attributes and latched read data with
//            a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xext_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ext_sel = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] data_in = '0;
  logic [31:0] ext_data_to_rd;
  logic        ext_stall;
  logic        ext_err;
  logic        bus_req;
  logic        bus_we;
  logic [11:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_rd = '0;   // model of the latched read data

  xext_bridge #(.DATA_W(32), .EXT_ADDR_W(12), .TIMEOUT(TO), .TO_W(8), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .ext_sel(ext_sel), .we(we), .addr(addr), .data_in(data_in),
    .ext_data_to_rd(ext_data_to_rd), .ext_stall(ext_stall), .ext_err(ext_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Transaction-level model: an ack on REQ cycle index a (0-based) within the
  // timeout window completes after a+1 request cycles and a+2 stall cycles;
  // otherwise the request lasts TO cycles, the CPU stalls TO+1 cycles and an
  // error pulse is raised with read data cleared.
  task automatic model(input logic a_we, input int a_ack_at, input logic [31:0] a_rd,
                       output int e_stalls, output int e_reqc, output int e_errs);
    if (a_ack_at >= 0 && a_ack_at < TO) begin
      e_stalls = a_ack_at + 2;
      e_reqc   = a_ack_at + 1;
      e_errs   = 0;
      if (!a_we) m_rd = a_rd;
    end else begin
      e_stalls = TO + 1;
      e_reqc   = TO;
      e_errs   = 1;
      m_rd     = '0;
    end
  endtask

  // Drives one access and records what the DUT did. Returns at the #1 point
  // of the release cycle with ext_sel still asserted.
  task automatic run_access(input logic a_we, input logic [31:0] a_addr, input logic [31:0] a_wd,
                            input int a_ack_at, input logic [31:0] a_rd,
                            output int o_stalls, output int o_reqc, output int o_errs,
                            output int o_lead, output int o_bad, output logic [31:0] o_rdout,
                            output bit o_to);
    int  cyc;
    bit  seen;
    bit  fin;
    logic [11:0] a_low;
    a_low = a_addr[11:0];
    @(negedge clk);
    ext_sel = 1'b1; we = a_we; addr = a_addr; data_in = a_wd;
    o_stalls = 0; o_reqc = 0; o_errs = 0; o_lead = 0; o_bad = 0; o_rdout = '0;
    cyc = 0; seen = 0; fin = 0;
    while (!fin && cyc < 64) begin
      if (bus_req) begin
        seen = 1;
        if (bus_addr !== a_low || bus_we !== a_we || bus_wdata !== a_wd) o_bad++;
        bus_ack   = (o_reqc == a_ack_at);
        bus_rdata = bus_ack ? a_rd : $urandom;
        o_reqc++;
      end else begin
        bus_ack = 1'b0;
        if (!seen) o_lead++;
      end
      if (ext_err) o_errs++;
      #1;
      if (ext_stall) o_stalls++;
      else begin
        fin = 1;
        o_rdout = ext_data_to_rd;
      end
      cyc++;
      if (!fin) @(negedge clk);
    end
    bus_ack = 1'b0;
    o_to = !fin;
  endtask

  task automatic go_idle(input int n);
    ext_sel = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    #1;
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL reset_bus_req got=%b exp=0", bus_req); end
    n_cmp++; if (bus_we !== 1'b0 || ext_err !== 1'b0) begin n_bad++; $display("FAIL reset_we_err got=%b%b exp=00", bus_we, ext_err); end
    n_cmp++; if (bus_addr !== 12'h0 || bus_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_addr_wdata got=%h/%h exp=0/0", bus_addr, bus_wdata); end
    n_cmp++; if (ext_data_to_rd !== 32'h0 || ext_stall !== 1'b0) begin n_bad++; $display("FAIL reset_rd_stall got=%h/%b exp=0/0", ext_data_to_rd, ext_stall); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read;
    int s, r, e, l, b, es, er, ee; logic [31:0] d; bit t;
    run_access(1'b0, 32'h0000_00A5, $urandom, 2, 32'hCAFE0001, s, r, e, l, b, d, t);
    model(1'b0, 2, 32'hCAFE0001, es, er, ee);
    n_cmp++; if (t) begin n_bad++; $display("FAIL read_timeout_bound got=expired exp=release"); end
    n_cmp++; if (s !== 4 || s !== es) begin n_bad++; $display("FAIL read_stalls got=%0d exp=4", s); end
    n_cmp++; if (r !== er || e !== ee) begin n_bad++; $display("FAIL read_req_err got=%0d/%0d exp=%0d/%0d", r, e, er, ee); end
    n_cmp++; if (b !== 0) begin n_bad++; $display("FAIL read_bus_attr got=%0d bad cycles exp=0", b); end
    n_cmp++; if (d !== 32'hCAFE0001) begin n_bad++; $display("FAIL read_data got=%h exp=cafe0001", d); end
    go_idle(2);
  endtask

  task automatic test_write;
    int s, r, e, l, b, es, er, ee; logic [31:0] d; bit t;
    run_access(1'b1, 32'h0000_0123, 32'h12345678, 0, $urandom, s, r, e, l, b, d, t);
    model(1'b1, 0, 32'h0, es, er, ee);
    n_cmp++; if (t || s !== 2 || s !== es) begin n_bad++; $display("FAIL write_stalls got=%0d exp=2", s); end
    n_cmp++; if (r !== er || e !== ee) begin n_bad++; $display("FAIL write_req_err got=%0d/%0d exp=%0d/%0d", r, e, er, ee); end
    n_cmp++; if (b !== 0) begin n_bad++; $display("FAIL write_bus_attr got=%0d bad cycles exp=0", b); end
    n_cmp++; if (d !== 32'hCAFE0001 || d !== m_rd) begin n_bad++; $display("FAIL write_rd_unchanged got=%h exp=cafe0001", d); end
    go_idle(1);
  endtask

  task automatic test_timeout;
    int s, r, e, l, b, es, er, ee; logic [31:0] d; bit t;
    run_access(1'b0, 32'h0000_0F0F, $urandom, -1, $urandom, s, r, e, l, b, d, t);
    model(1'b0, -1, 32'h0, es, er, ee);
    n_cmp++; if (t || s !== es) begin n_bad++; $display("FAIL timeout_stalls got=%0d exp=%0d", s, es); end
    n_cmp++; if (r !== 4) begin n_bad++; $display("FAIL timeout_req_cycles got=%0d exp=4", r); end
    n_cmp++; if (e !== 1) begin n_bad++; $display("FAIL timeout_err_pulses got=%0d exp=1", e); end
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL timeout_rd got=%h exp=0", d); end
    ext_sel = 1'b0;
    @(negedge clk);
    n_cmp++; if (ext_err !== 1'b0) begin n_bad++; $display("FAIL timeout_err_cleared got=%b exp=0", ext_err); end
    go_idle(1);
  endtask

  task automatic test_ack_on_last;
    int s, r, e, l, b, es, er, ee; logic [31:0] d, rd; bit t;
    rd = $urandom;
    run_access(1'b0, 32'h0000_0777, $urandom, TO - 1, rd, s, r, e, l, b, d, t);
    model(1'b0, TO - 1, rd, es, er, ee);
    n_cmp++; if (t || s !== es || r !== er) begin n_bad++; $display("FAIL lastack_timing got=%0d/%0d exp=%0d/%0d", s, r, es, er); end
    n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL lastack_err got=%0d exp=0", e); end
    n_cmp++; if (d !== rd) begin n_bad++; $display("FAIL lastack_data got=%h exp=%h", d, rd); end
    go_idle(1);
  endtask

  task automatic test_back_to_back;
    int s, r, e, l, b, es, er, ee; logic [31:0] d, rd1, rd2; bit t;
    rd1 = $urandom; rd2 = $urandom;
    run_access(1'b0, 32'hABCD_E111, $urandom, 1, rd1, s, r, e, l, b, d, t);
    model(1'b0, 1, rd1, es, er, ee);
    n_cmp++; if (t || s !== es || d !== rd1) begin n_bad++; $display("FAIL b2b_first got=%0d/%h exp=%0d/%h", s, d, es, rd1); end
    // ext_sel stays high: the next access begins in the cycle after DONE.
    run_access(1'b0, 32'h0000_0222, $urandom, 0, rd2, s, r, e, l, b, d, t);
    model(1'b0, 0, rd2, es, er, ee);
    // Low gap = DONE cycle + the IDLE cycle that launches the next request.
    n_cmp++; if (1 + l !== 2) begin n_bad++; $display("FAIL b2b_req_gap got=%0d exp=2", 1 + l); end
    n_cmp++; if (t || s !== es || b !== 0) begin n_bad++; $display("FAIL b2b_second got=%0d/%0d exp=%0d/0", s, b, es); end
    n_cmp++; if (d !== rd2) begin n_bad++; $display("FAIL b2b_data got=%h exp=%h", d, rd2); end
    go_idle(1);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    ext_sel = 1'b1; we = 1'b1; addr = 32'h0000_03C3; data_in = 32'h5A5A_A5A5;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_req got=%b exp=1", bus_req); end
    #2 rst = 1'b0;
    #1;
    m_rd = '0;
    n_cmp++; if (bus_req !== 1'b0 || ext_err !== 1'b0) begin n_bad++; $display("FAIL rstmid_async got=%b%b exp=00", bus_req, ext_err); end
    n_cmp++; if (bus_addr !== 12'h0 || bus_wdata !== 32'h0 || bus_we !== 1'b0 || ext_data_to_rd !== m_rd) begin
      n_bad++; $display("FAIL rstmid_outputs got=%h/%h/%b/%h exp=0/0/0/0", bus_addr, bus_wdata, bus_we, ext_data_to_rd);
    end
    ext_sel = 1'b0;
    @(negedge clk);
    rst = 1'b1; bus_ack = 1'b1; bus_rdata = $urandom;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (bus_req !== 1'b0 || ext_stall !== 1'b0 || ext_data_to_rd !== m_rd) begin
        n_bad++; $display("FAIL rstmid_stray_ack cyc=%0d got=%b/%b/%h exp=0/0/%h", i, bus_req, ext_stall, ext_data_to_rd, m_rd);
      end
    end
    bus_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random;
    int s, r, e, l, b, es, er, ee, ack_at; logic [31:0] d, rd, ad, wd; logic w; bit t;
    for (int i = 0; i < 30; i++) begin
      w = 1'($urandom_range(0, 1)); ad = $urandom; wd = $urandom; rd = $urandom;
      ack_at = int'($urandom_range(0, TO + 1));
      if (ack_at >= TO) ack_at = -1;
      run_access(w, ad, wd, ack_at, rd, s, r, e, l, b, d, t);
      model(w, ack_at, rd, es, er, ee);
      n_cmp++; if (t || s !== es || r !== er || e !== ee || b !== 0 || d !== m_rd) begin
        n_bad++; $display("FAIL random[%0d] got=st%0d rq%0d er%0d bad%0d rd%h exp=st%0d rq%0d er%0d bad0 rd%h",
                          i, s, r, e, b, d, es, er, ee, m_rd);
      end
      if ($urandom_range(0, 2) != 0) go_idle(int'($urandom_range(1, 2)));
    end
    go_idle(1);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_ack_on_last();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
